// File: rtl/unified_mem_arbiter_if.sv
// Bundle between the IF/MEM requesters, the shared-memory arbiter and the RAM macro.
// Handshake: a requester raises x_req and holds its command stable until the single-cycle x_ack.
// The arbiter issues at most one RAM access per cycle and acks it exactly RD_LAT cycles later.
interface unified_mem_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;
  logic [DATA_W-1:0] mem_rdata;

  logic              ram_en;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    output if_ack, if_rdata, mem_ack, mem_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_wdata, ram_rdata,
    input  if_ack, if_rdata, mem_ack, mem_rdata, ram_en, ram_we, ram_addr, ram_wdata
  );
endinterface

// File: rtl/unified_mem_arbiter.sv
// Arbiter sharing one single-port synchronous-read RAM between instruction fetch and MEM.
// MEM has fixed priority; a requester with a transaction in flight is not eligible.
module unified_mem_arbiter #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  unified_mem_arbiter_if.slave  bus
);

  // Tag pipeline: one entry per issued access; src=1 marks MEM, wr=1 marks a store.
  logic [RD_LAT-1:0] vld_q, vld_d;
  logic [RD_LAT-1:0] src_q, src_d;
  logic [RD_LAT-1:0] wr_q,  wr_d;

  logic [DATA_W-1:0] if_rdata_q,  if_rdata_d;
  logic [DATA_W-1:0] mem_rdata_q, mem_rdata_d;

  logic if_busy, mem_busy;
  logic grant_mem, grant_if;
  logic if_ack, mem_ack, mem_ld_ack;
  logic unused_addr_bits;

  assign unused_addr_bits = ^{bus.if_addr[31:ADDR_W+2],  bus.if_addr[1:0],
                              bus.mem_addr[31:ADDR_W+2], bus.mem_addr[1:0]};

  // In flight spans issue through ack, so a held req cannot re-issue in its own ack cycle.
  always_comb begin
    if_busy  = 1'b0;
    mem_busy = 1'b0;
    for (int i = 0; i < RD_LAT; i++) begin
      if_busy  = if_busy  | (vld_q[i] & ~src_q[i]);
      mem_busy = mem_busy | (vld_q[i] &  src_q[i]);
    end
  end

  assign grant_mem = rst & bus.mem_req & ~mem_busy;
  assign grant_if  = rst & bus.if_req  & ~if_busy & ~grant_mem;

  assign if_ack     = rst & vld_q[RD_LAT-1] & ~src_q[RD_LAT-1];
  assign mem_ack    = rst & vld_q[RD_LAT-1] &  src_q[RD_LAT-1];
  assign mem_ld_ack = mem_ack & ~wr_q[RD_LAT-1];

  always_comb begin
    bus.ram_en    = 1'b0;
    bus.ram_we    = 1'b0;
    bus.ram_addr  = '0;
    bus.ram_wdata = '0;
    if (grant_mem) begin
      bus.ram_en    = 1'b1;
      bus.ram_we    = bus.mem_we;
      bus.ram_addr  = bus.mem_addr[ADDR_W+1:2];
      bus.ram_wdata = bus.mem_wdata;
    end else if (grant_if) begin
      bus.ram_en    = 1'b1;
      bus.ram_addr  = bus.if_addr[ADDR_W+1:2];
    end
  end

  always_comb begin
    bus.if_ack    = if_ack;
    bus.mem_ack   = mem_ack;
    bus.if_rdata  = '0;
    bus.mem_rdata = '0;
    if (rst) begin
      bus.if_rdata  = if_ack     ? bus.ram_rdata : if_rdata_q;
      bus.mem_rdata = mem_ld_ack ? bus.ram_rdata : mem_rdata_q;
    end
  end

  always_comb begin
    vld_d    = '0;
    src_d    = '0;
    wr_d     = '0;
    vld_d[0] = grant_mem | grant_if;
    src_d[0] = grant_mem;
    wr_d[0]  = grant_mem & bus.mem_we;
    for (int i = 1; i < RD_LAT; i++) begin
      vld_d[i] = vld_q[i-1];
      src_d[i] = src_q[i-1];
      wr_d[i]  = wr_q[i-1];
    end
    if_rdata_d  = if_ack     ? bus.ram_rdata : if_rdata_q;
    mem_rdata_d = mem_ld_ack ? bus.ram_rdata : mem_rdata_q;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_q       <= '0;
      src_q       <= '0;
      wr_q        <= '0;
      if_rdata_q  <= '0;
      mem_rdata_q <= '0;
    end else begin
      vld_q       <= vld_d;
      src_q       <= src_d;
      wr_q        <= wr_d;
      if_rdata_q  <= if_rdata_d;
      mem_rdata_q <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Directed bench for unified_mem_arbiter: one instance with RD_LAT=1, one with RD_LAT=2.
// Each has a behavioural RAM and ack scoreboards fed when requests are driven.
module tb_unified_mem_arbiter;

  logic clk;
  logic rst1, rst2;
  int   total = 0;
  int   bad   = 0;

  logic [31:0] if1_q[$];
  logic [31:0] mem1_q[$];
  logic [31:0] if2_q[$];
  logic [31:0] mem2_q[$];

  unified_mem_arbiter_if #(.ADDR_W(14), .DATA_W(32)) b1();
  unified_mem_arbiter_if #(.ADDR_W(14), .DATA_W(32)) b2();

  unified_mem_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(1)) u_dut1 (
    .clk (clk),
    .rst (rst1),
    .bus (b1)
  );

  unified_mem_arbiter #(.ADDR_W(14), .DATA_W(32), .RD_LAT(2)) u_dut2 (
    .clk (clk),
    .rst (rst2),
    .bus (b2)
  );

  // clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // behavioural RAMs
  logic [31:0] ram1 [0:16383];
  logic [31:0] ram2 [0:16383];
  logic [31:0] rd1, rd2a, rd2b;

  always @(posedge clk) begin
    if (b1.ram_en) begin
      if (b1.ram_we) ram1[b1.ram_addr] <= b1.ram_wdata;
      rd1 <= ram1[b1.ram_addr];
    end
    if (b2.ram_en) begin
      if (b2.ram_we) ram2[b2.ram_addr] <= b2.ram_wdata;
      rd2a <= ram2[b2.ram_addr];
    end
    rd2b <= rd2a;
  end

  assign b1.ram_rdata = rd1;
  assign b2.ram_rdata = rd2b;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic unexp(input string tag);
    total++;
    bad++;
    $error("FAIL %s: observed=ack expected=no_ack", tag);
  endtask

  // scoreboards
  always @(negedge clk) begin
    if (b1.if_ack || b1.mem_ack) chk("d1_ack_excl", 32'(b1.if_ack & b1.mem_ack), 0);
    if (b1.if_ack) begin
      if (if1_q.size() == 0) unexp("d1_if_ack");
      else chk("d1_if_rdata", b1.if_rdata, if1_q.pop_front());
    end
    if (b1.mem_ack) begin
      if (mem1_q.size() == 0) unexp("d1_mem_ack");
      else chk("d1_mem_rdata", b1.mem_rdata, mem1_q.pop_front());
    end
  end

  always @(negedge clk) begin
    if (b2.if_ack || b2.mem_ack) chk("d2_ack_excl", 32'(b2.if_ack & b2.mem_ack), 0);
    if (b2.if_ack) begin
      if (if2_q.size() == 0) unexp("d2_if_ack");
      else chk("d2_if_rdata", b2.if_rdata, if2_q.pop_front());
    end
    if (b2.mem_ack) begin
      if (mem2_q.size() == 0) unexp("d2_mem_ack");
      else chk("d2_mem_rdata", b2.mem_rdata, mem2_q.pop_front());
    end
  end

  // driver tasks
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic if_op(input logic [31:0] addr, input logic [31:0] exp_addr,
                       input logic [31:0] exp_data);
    b1.if_req  = 1'b1;
    b1.if_addr = addr;
    #1;
    chk("if_issue_en",   32'(b1.ram_en), 1);
    chk("if_issue_we",   32'(b1.ram_we), 0);
    chk("if_issue_addr", 32'(b1.ram_addr), exp_addr);
    if1_q.push_back(exp_data);
    cyc();
    chk("if_ack",        32'(b1.if_ack), 1);
    chk("if_no_reissue", 32'(b1.ram_en), 0);
    cyc();
    b1.if_req = 1'b0;
    #1;
    chk("if_rdata_hold", b1.if_rdata, exp_data);
  endtask

  task automatic mem_op(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] exp_addr, input logic [31:0] exp_rdata);
    b1.mem_req   = 1'b1;
    b1.mem_we    = we;
    b1.mem_addr  = addr;
    b1.mem_wdata = wdata;
    #1;
    chk("mem_issue_en",    32'(b1.ram_en), 1);
    chk("mem_issue_we",    32'(b1.ram_we), 32'(we));
    chk("mem_issue_addr",  32'(b1.ram_addr), exp_addr);
    chk("mem_issue_wdata", b1.ram_wdata, wdata);
    mem1_q.push_back(exp_rdata);
    cyc();
    chk("mem_ack",         32'(b1.mem_ack), 1);
    chk("mem_no_reissue",  32'(b1.ram_en), 0);
    cyc();
    b1.mem_req = 1'b0;
    #1;
    chk("mem_rdata_hold",  b1.mem_rdata, exp_rdata);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench timed out");
  end

  initial begin
    rst1 = 1'b0;
    rst2 = 1'b0;
    b1.if_req = 1'b1;  b1.if_addr = 32'h10;
    b1.mem_req = 1'b1; b1.mem_we = 1'b1; b1.mem_addr = 32'h10; b1.mem_wdata = 32'hDEADBEEF;
    b2.if_req = 1'b0;  b2.if_addr = '0;
    b2.mem_req = 1'b0; b2.mem_we = 1'b0; b2.mem_addr = '0; b2.mem_wdata = '0;

    // reset held with both requests asserted
    #2;
    for (int i = 0; i < 3; i++) begin
      chk("rst_ram_en",    32'(b1.ram_en), 0);
      chk("rst_if_ack",    32'(b1.if_ack), 0);
      chk("rst_mem_ack",   32'(b1.mem_ack), 0);
      chk("rst_if_rdata",  b1.if_rdata, 0);
      chk("rst_mem_rdata", b1.mem_rdata, 0);
      cyc();
      #1;
    end

    // first cycle out of reset: MEM store wins
    cyc();
    rst1 = 1'b1;
    rst2 = 1'b1;
    #1;
    chk("a0_en",    32'(b1.ram_en), 1);
    chk("a0_we",    32'(b1.ram_we), 1);
    chk("a0_addr",  32'(b1.ram_addr), 4);
    chk("a0_wdata", b1.ram_wdata, 32'hDEADBEEF);
    mem1_q.push_back(32'h0);
    cyc();
    chk("a1_mem_ack", 32'(b1.mem_ack), 1);
    chk("a1_if_en",   32'(b1.ram_en), 1);
    chk("a1_if_we",   32'(b1.ram_we), 0);
    chk("a1_if_addr", 32'(b1.ram_addr), 4);
    if1_q.push_back(32'hDEADBEEF);
    cyc();
    b1.mem_req = 1'b0;
    #1;
    chk("a2_if_ack",   32'(b1.if_ack), 1);
    chk("a2_if_rdata", b1.if_rdata, 32'hDEADBEEF);
    chk("a2_idle",     32'(b1.ram_en), 0);
    cyc();
    chk("a3_reissue_en",   32'(b1.ram_en), 1);
    chk("a3_reissue_addr", 32'(b1.ram_addr), 4);
    if1_q.push_back(32'hDEADBEEF);
    cyc();
    b1.if_req = 1'b0;
    #1;
    chk("a4_if_ack", 32'(b1.if_ack), 1);
    chk("a4_idle",   32'(b1.ram_en), 0);
    cyc();
    chk("a5_if_hold",  b1.if_rdata, 32'hDEADBEEF);
    chk("a5_mem_hold", b1.mem_rdata, 32'h0);

    // store then load, then address wrap / low-bit masking
    cyc(); mem_op(1'b1, 32'h20, 32'h12345678, 8, 32'h0);
    cyc(); mem_op(1'b0, 32'h20, 32'h0,        8, 32'h12345678);
    cyc(); if_op(32'h0001_0010, 4, 32'hDEADBEEF);
    cyc(); if_op(32'h0000_0023, 8, 32'h12345678);
    cyc(); if_op(32'hFFFF_0010, 4, 32'hDEADBEEF);

    // RD_LAT=1 contention: M,I,M,I...
    cyc();
    b1.if_req = 1'b1;  b1.if_addr = 32'h10;
    b1.mem_req = 1'b1; b1.mem_we = 1'b0; b1.mem_addr = 32'h20;
    for (int k = 0; k < 8; k++) begin
      if (k > 0) cyc();
      else #1;
      chk("c_en",      32'(b1.ram_en), 1);
      chk("c_addr",    32'(b1.ram_addr), (k % 2 == 0) ? 32'd8 : 32'd4);
      chk("c_mem_ack", 32'(b1.mem_ack), (k % 2 == 1) ? 32'd1 : 32'd0);
      chk("c_if_ack",  32'(b1.if_ack), (k > 0 && k % 2 == 0) ? 32'd1 : 32'd0);
      if (k % 2 == 0) mem1_q.push_back(32'h12345678);
      else            if1_q.push_back(32'hDEADBEEF);
    end
    cyc();
    b1.if_req = 1'b0;
    b1.mem_req = 1'b0;
    #1;
    chk("c_last_if_ack", 32'(b1.if_ack), 1);
    chk("c_drain_idle",  32'(b1.ram_en), 0);
    cyc();
    chk("c_mem_hold",    b1.mem_rdata, 32'h12345678);

    // reset in the cycle after an IF issue: no ack, rdata cleared
    cyc();
    b1.if_req = 1'b1; b1.if_addr = 32'h20;
    #1;
    chk("r_issue_en",   32'(b1.ram_en), 1);
    chk("r_issue_addr", 32'(b1.ram_addr), 8);
    cyc();
    rst1 = 1'b0;
    b1.if_req = 1'b0;
    #1;
    chk("r_no_ack",     32'(b1.if_ack), 0);
    chk("r_if_rdata",   b1.if_rdata, 0);
    chk("r_mem_rdata",  b1.mem_rdata, 0);
    cyc();
    rst1 = 1'b1;
    #1;
    chk("r_post_ack",   32'(b1.if_ack), 0);
    chk("r_post_rdata", b1.if_rdata, 0);
    chk("r_post_mem",   b1.mem_rdata, 0);
    chk("r_post_en",    32'(b1.ram_en), 0);
    cyc(); if_op(32'h20, 8, 32'h12345678);

    // RD_LAT=2: store, then contention M,I,idle...
    cyc();
    b2.mem_req = 1'b1; b2.mem_we = 1'b1; b2.mem_addr = 32'h40; b2.mem_wdata = 32'hA5A5A5A5;
    #1;
    chk("l2_st_en",   32'(b2.ram_en), 1);
    chk("l2_st_we",   32'(b2.ram_we), 1);
    chk("l2_st_addr", 32'(b2.ram_addr), 16);
    mem2_q.push_back(32'h0);
    cyc();
    chk("l2_st_wait_en",  32'(b2.ram_en), 0);
    chk("l2_st_wait_ack", 32'(b2.mem_ack), 0);
    cyc();
    chk("l2_st_ack",      32'(b2.mem_ack), 1);
    chk("l2_st_ack_en",   32'(b2.ram_en), 0);
    cyc();
    b2.mem_req = 1'b0; b2.mem_we = 1'b0;
    cyc();
    b2.if_req = 1'b1;  b2.if_addr = 32'h40;
    b2.mem_req = 1'b1; b2.mem_addr = 32'h40;
    for (int k = 0; k < 9; k++) begin
      if (k > 0) cyc();
      else #1;
      chk("l2_en",      32'(b2.ram_en), (k % 3 != 2) ? 32'd1 : 32'd0);
      chk("l2_mem_ack", 32'(b2.mem_ack), (k % 3 == 2) ? 32'd1 : 32'd0);
      chk("l2_if_ack",  32'(b2.if_ack), (k >= 3 && k % 3 == 0) ? 32'd1 : 32'd0);
      if (k % 3 != 2) chk("l2_addr", 32'(b2.ram_addr), 16);
      if (k % 3 == 0) mem2_q.push_back(32'hA5A5A5A5);
      if (k % 3 == 1) if2_q.push_back(32'hA5A5A5A5);
    end
    cyc();
    b2.if_req = 1'b0;
    b2.mem_req = 1'b0;
    #1;
    chk("l2_last_if_ack", 32'(b2.if_ack), 1);
    chk("l2_drain_idle",  32'(b2.ram_en), 0);
    cyc();
    cyc();
    chk("l2_if_hold",  b2.if_rdata, 32'hA5A5A5A5);
    chk("l2_mem_hold", b2.mem_rdata, 32'hA5A5A5A5);

    // final report
    chk("d1_if_q_empty",  32'(if1_q.size()), 0);
    chk("d1_mem_q_empty", 32'(mem1_q.size()), 0);
    chk("d2_if_q_empty",  32'(if2_q.size()), 0);
    chk("d2_mem_q_empty", 32'(mem2_q.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
